// File: rtl/fifo_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : fifo_uart_tx
//  Brief    : UART transmitter acting as the read side of a first-word-fall-
//             through FIFO. Pops one word per frame and serializes it as
//             start bit, DBIT data bits (LSB first) and a stop interval, timed
//             by an external 16x-oversampling baud tick.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DBIT    = 8,   // data bits per frame
    parameter int SB_TICK = 16   // stop length in s_tick pulses (16/24/32)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_en,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [4:0]    C_S_LAST  = 5'd15;
    localparam logic [4:0]    C_SB_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] C_N_LAST  = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      s_q, s_d;      // oversampling tick counter
    logic [NW-1:0]   n_q, n_d;      // data bit counter
    logic [DBIT-1:0] b_q, b_d;      // shift register, bit 0 is on the line
    logic            tx_q, tx_d;

    // Next-state logic; rd and tx_done_tick are Mealy strobes and are held
    // low while reset is asserted so no word is popped into a frame that the
    // same edge would discard.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        rd           = 1'b0;
        tx_done_tick = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_en && !empty) begin
                    rd      = 1'b1;
                    b_d     = r_data;
                    s_d     = 5'd0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == C_S_LAST) begin
                        s_d     = 5'd0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == C_S_LAST) begin
                        s_d = 5'd0;
                        b_d = b_q >> 1;
                        if (n_q == C_N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == C_SB_LAST) begin
                        tx_done_tick = 1'b1;
                        s_d          = 5'd0;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            rd           = 1'b0;
            tx_done_tick = 1'b0;
        end
    end

    // Line level follows the state being entered, so tx drops on the very
    // edge that enters START and each data bit appears with its shift.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 5'd0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Brief    : Self-checking bench for fifo_uart_tx with a queue-based FIFO and
//             a tick-count reference model of the serial line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int DBIT  = 8;
    localparam int TOTAL = 16 * (1 + DBIT) + 16;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_en  = 1'b0;
    logic       empty  = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd, tx, tx_busy, tx_done_tick;

    logic       empty32  = 1'b1;
    logic [7:0] r_data32 = 8'h00;
    logic       tx_en32  = 1'b0;
    logic       rd32, tx32, busy32, done32;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_en(tx_en),
        .empty(empty), .r_data(r_data), .rd(rd), .tx(tx),
        .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    fifo_uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_en(tx_en32),
        .empty(empty32), .r_data(r_data32), .rd(rd32), .tx(tx32),
        .tx_busy(busy32), .tx_done_tick(done32)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] fifo[$];
    logic [7:0] fifo32[$];
    logic       txlog[$];
    int         rd_cycs[$];
    int         done_cycs[$];
    bit         ten   = 1'b0;
    bit         ten32 = 1'b0;

    // reference model: frame in progress, ticks seen since START entry, word
    bit         m_busy = 1'b0;
    int         m_cnt  = 0;
    logic [7:0] m_word = 8'h00;

    bit         p_rd = 1'b0, p_erd = 1'b0, p_tick = 1'b0, p_rst = 1'b1, p_rd32 = 1'b0;
    logic [7:0] p_head = 8'h00;

    function automatic logic exp_line();
        int pos;
        pos = m_cnt / 16;
        if (pos == 0) return 1'b0;
        if (pos <= DBIT) return m_word[pos-1];
        return 1'b1;
    endfunction

    // decode a frame from the line log, one tick per clk, sampling mid-bit
    function automatic logic [7:0] decode(input int rc);
        logic [7:0] d;
        int idx;
        d = 8'hxx;
        for (int k = 0; k < 8; k++) begin
            idx = rc + 16 * (k + 1) + 8 - 1;
            if (idx >= 0 && idx < txlog.size()) d[k] = txlog[idx];
        end
        return d;
    endfunction

    task automatic step(input bit tick, input bit rst);
        logic e_tx, e_rd, e_done, e_busy;
        @(negedge clk);
        cyc++;
        if (p_rd   && fifo.size()   > 0) void'(fifo.pop_front());
        if (p_rd32 && fifo32.size() > 0) void'(fifo32.pop_front());
        if (p_rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (p_erd) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_word = p_head;
        end else if (m_busy && p_tick) begin
            m_cnt++;
            if (m_cnt == TOTAL) m_busy = 1'b0;
        end
        empty    = (fifo.size() == 0);
        r_data   = empty ? 8'h00 : fifo[0];
        empty32  = (fifo32.size() == 0);
        r_data32 = empty32 ? 8'h00 : fifo32[0];
        tx_en    = ten;
        tx_en32  = ten32;
        s_tick   = tick;
        reset    = rst;
        #1;
        e_busy = m_busy;
        e_tx   = m_busy ? exp_line() : 1'b1;
        e_rd   = !m_busy && ten && !empty && !rst;
        e_done = m_busy && tick && !rst && (m_cnt == TOTAL - 1);
        checks += 4;
        if (tx !== e_tx) begin
            failures++;
            $display("FAIL cyc%0d_tx: got %b expected %b", cyc, tx, e_tx);
        end
        if (rd !== e_rd) begin
            failures++;
            $display("FAIL cyc%0d_rd: got %b expected %b", cyc, rd, e_rd);
        end
        if (tx_busy !== e_busy) begin
            failures++;
            $display("FAIL cyc%0d_busy: got %b expected %b", cyc, tx_busy, e_busy);
        end
        if (tx_done_tick !== e_done) begin
            failures++;
            $display("FAIL cyc%0d_done: got %b expected %b", cyc, tx_done_tick, e_done);
        end
        txlog.push_back(tx);
        if (rd === 1'b1) rd_cycs.push_back(cyc);
        if (tx_done_tick === 1'b1) done_cycs.push_back(cyc);
        p_rd   = (rd === 1'b1);
        p_erd  = e_rd;
        p_head = r_data;
        p_tick = tick;
        p_rst  = rst;
        p_rd32 = (rd32 === 1'b1);
    endtask

    task automatic test_reset();
        int bad;
        ten = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks += 3;
        if (tx !== 1'b1)      begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        if (rd !== 1'b0)      begin failures++; $display("FAIL reset_rd: got %b expected 0", rd); end
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        bad = 0;
        repeat (200) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            if (tx !== 1'b1 || rd !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL idle_200: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_single();
        int guard;
        int diff;
        logic exp_slot[10];
        logic got;
        exp_slot = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rd_cycs.delete();
        done_cycs.delete();
        fifo.push_back(8'h07);
        ten = 1'b1;
        guard = 0;
        while (done_cycs.size() == 0 && guard < 400) begin
            step(1'b1, 1'b0);
            guard++;
        end
        diff = (rd_cycs.size() > 0 && done_cycs.size() > 0) ? done_cycs[0] - rd_cycs[0] : -1;
        checks += 3;
        if (rd_cycs.size() != 1) begin failures++; $display("FAIL single_rd_pulses: got %0d expected 1", rd_cycs.size()); end
        if (diff != 160) begin failures++; $display("FAIL single_latency: got %0d expected 160", diff); end
        if (empty !== 1'b1) begin failures++; $display("FAIL single_empty: got %b expected 1", empty); end
        if (rd_cycs.size() > 0) begin
            for (int k = 0; k < 10; k++) begin
                got = txlog[rd_cycs[0] + 16 * k + 8];
                checks++;
                if (got !== exp_slot[k]) begin
                    failures++;
                    $display("FAIL single_slot%0d: got %b expected %b", k, got, exp_slot[k]);
                end
            end
        end
        ten = 1'b0;
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_w[3];
        int guard;
        exp_w = '{8'h07, 8'h08, 8'h06};
        rd_cycs.delete();
        done_cycs.delete();
        for (int i = 0; i < 3; i++) fifo.push_back(exp_w[i]);
        ten = 1'b1;
        guard = 0;
        while (done_cycs.size() < 3 && guard < 1000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        checks += 2;
        if (rd_cycs.size() != 3) begin failures++; $display("FAIL b2b_rd_pulses: got %0d expected 3", rd_cycs.size()); end
        if (done_cycs.size() != 3) begin failures++; $display("FAIL b2b_done_count: got %0d expected 3", done_cycs.size()); end
        if (rd_cycs.size() == 3 && done_cycs.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (decode(rd_cycs[i]) !== exp_w[i]) begin
                    failures++;
                    $display("FAIL b2b_word%0d: got %h expected %h", i, decode(rd_cycs[i]), exp_w[i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rd_cycs[i+1] - done_cycs[i] != 1) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: got %0d expected 1", i, rd_cycs[i+1] - done_cycs[i]);
                end
            end
        end
        ten = 1'b0;
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic test_gating();
        int t;
        int guard;
        int diff;
        rd_cycs.delete();
        done_cycs.delete();
        fifo.push_back(8'hA5);
        fifo.push_back(8'h3C);
        ten = 1'b0;
        repeat (60) step(1'b1, 1'b0);
        checks++;
        if (rd_cycs.size() != 0) begin failures++; $display("FAIL gate_no_rd: got %0d expected 0", rd_cycs.size()); end
        ten = 1'b1;
        t = 0;
        guard = 0;
        while (done_cycs.size() == 0 && guard < 1200) begin
            if (t == 300) ten = 1'b0;
            step(1'((t % 4) == 0), 1'b0);
            t++;
            guard++;
        end
        diff = (rd_cycs.size() > 0 && done_cycs.size() > 0) ? done_cycs[0] - rd_cycs[0] : -1;
        checks++;
        if (diff != 640) begin failures++; $display("FAIL gate_frame_len: got %0d expected 640", diff); end
        repeat (100) begin
            step(1'((t % 4) == 0), 1'b0);
            t++;
        end
        checks += 2;
        if (rd_cycs.size() != 1) begin failures++; $display("FAIL gate_single_pop: got %0d expected 1", rd_cycs.size()); end
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL gate_idle_after: got %b expected 0", tx_busy); end
        fifo.delete();
    endtask

    task automatic test_reset_mid();
        int guard;
        int diff;
        rd_cycs.delete();
        done_cycs.delete();
        fifo.push_back(8'hFF);
        fifo.push_back(8'h11);
        ten = 1'b1;
        guard = 0;
        while (rd_cycs.size() == 0 && guard < 10) begin
            step(1'b1, 1'b0);
            guard++;
        end
        if (rd_cycs.size() > 0) begin
            while (cyc < rd_cycs[0] + 72) step(1'b1, 1'b0);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        checks += 3;
        if (tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", tx_busy); end
        if (rd !== 1'b1) begin failures++; $display("FAIL rstmid_repop: got %b expected 1", rd); end
        guard = 0;
        while (done_cycs.size() == 0 && guard < 400) begin
            step(1'b1, 1'b0);
            guard++;
        end
        diff = (rd_cycs.size() == 2 && done_cycs.size() > 0) ? done_cycs[0] - rd_cycs[1] : -1;
        checks += 3;
        if (rd_cycs.size() != 2) begin failures++; $display("FAIL rstmid_pops: got %0d expected 2", rd_cycs.size()); end
        if (diff != 160) begin failures++; $display("FAIL rstmid_len: got %0d expected 160", diff); end
        if (rd_cycs.size() == 2 && decode(rd_cycs[1]) !== 8'h11) begin
            failures++;
            $display("FAIL rstmid_word: got %h expected 11", decode(rd_cycs[1]));
        end
        ten = 1'b0;
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic test_stop32();
        int rc;
        int dc;
        int hirun;
        int hi_at_done;
        int guard;
        rc = -1;
        dc = -1;
        hirun = 0;
        hi_at_done = -1;
        fifo32.push_back(8'h00);
        ten32 = 1'b1;
        guard = 0;
        while (dc < 0 && guard < 400) begin
            step(1'b1, 1'b0);
            if (rd32 === 1'b1 && rc < 0) rc = cyc;
            if (tx32 === 1'b1) hirun++;
            else hirun = 0;
            if (done32 === 1'b1) begin
                dc = cyc;
                hi_at_done = hirun;
            end
            guard++;
        end
        ten32 = 1'b0;
        checks += 2;
        if (dc - rc != 176 || rc < 0) begin failures++; $display("FAIL stop32_len: got %0d expected 176", dc - rc); end
        if (hi_at_done != 32) begin failures++; $display("FAIL stop32_high: got %0d expected 32", hi_at_done); end
        step(1'b1, 1'b0);
        checks++;
        if (busy32 !== 1'b0) begin failures++; $display("FAIL stop32_idle: got %b expected 0", busy32); end
    endtask

    task automatic test_random();
        int dens;
        bit rst;
        dens = 1;
        for (int i = 0; i < 6000; i++) begin
            if (i % 1000 == 0) dens = $urandom_range(1, 4);
            if ($urandom_range(0, 49) == 0) ten = ~ten;
            if (fifo.size() < 4 && $urandom_range(0, 59) == 0) fifo.push_back(8'($urandom_range(0, 255)));
            rst = ($urandom_range(0, 1999) == 0);
            step(1'($urandom_range(1, dens) == 1), rst);
        end
        ten = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gating();
        test_reset_mid();
        test_stop32();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
